// File: rtl/coherent_frame_receiver.sv
// coherent_frame_receiver
// Captures one frame of M averaged words from the coherent averager and
// normalises each word by 2^SHIFT on the way into a local frame buffer.
// Once the frame is held it raises frame_ready and serves random-access
// reads with one cycle of latency.
// Optional build macro: COHERENT_FRAME_RX_ROUND_EN selects round-half-up
// normalisation. Left undefined, normalisation is a plain truncating shift.

module coherent_frame_receiver #(
    parameter int M      = 32,
    parameter int ADDR_W = 5,
    parameter int Q_in   = 32,
    parameter int Q_out  = 32,
    parameter int SHIFT  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm,
    input  logic [Q_in-1:0]     data_in,
    input  logic                data_in_valid,
    output logic                frame_ready,
    output logic                capturing,
    output logic [ADDR_W:0]     word_count,
    output logic [15:0]         drop_count,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [Q_out-1:0]    rd_data,
    output logic                rd_valid
);

    // The normalisation datapath is one bit wider than the wider of the two
    // word widths. That leaves room for the rounding increment and still
    // lets an oversized result be detected before it is clipped.
    localparam int NW = ((Q_in > Q_out) ? Q_in : Q_out) + 1;
    localparam logic [Q_out-1:0] MAX_OUT = {Q_out{1'b1}};
    localparam logic [ADDR_W:0]  LAST_WC = (ADDR_W + 1)'(M - 1);
    localparam logic [ADDR_W:0]  FULL_WC = (ADDR_W + 1)'(M);

`ifdef COHERENT_FRAME_RX_ROUND_EN
    // Half of one output LSB, i.e. 2^(SHIFT-1). This is zero when SHIFT is 0.
    localparam logic [NW-1:0] RND = (NW'(1) << SHIFT) >> 1;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [15:0]       dc_q, dc_d;
    logic              fr_q, fr_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [Q_out-1:0]  wr_data;
    logic              rd_ok;

    // Frame buffer. It has no reset, so an aborted capture leaves stale data
    // behind. Writes happen only in CAPTURE and reads return data only in
    // READY, so a same-address read/write collision can never occur.
    logic [Q_out-1:0]  mem [M];

    // Zero-extend, optionally round, shift down, then clip to the output range.
    function automatic logic [Q_out-1:0] norm(input logic [Q_in-1:0] x);
        logic [NW-1:0] ext;
        logic [NW-1:0] shf;
        ext = NW'(x);
`ifdef COHERENT_FRAME_RX_ROUND_EN
        ext = ext + RND;
`endif
        shf = ext >> SHIFT;
        if (shf > NW'(MAX_OUT))
            return MAX_OUT;
        else
            return shf[Q_out-1:0];
    endfunction

    assign wr_addr = wc_q[ADDR_W-1:0];
    assign wr_data = norm(data_in);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wc_q    <= '0;
            dc_q    <= '0;
            fr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            dc_q    <= dc_d;
            fr_q    <= fr_d;
        end
    end

    // Next-state logic. When arm and a valid word arrive together, arm wins
    // and the word is discarded.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        dc_d    = dc_q;
        fr_d    = fr_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = CAPTURE;
                    wc_d    = '0;
                end
            end
            CAPTURE: begin
                if (arm) begin
                    wc_d = '0;
                end else if (data_in_valid) begin
                    wr_en = 1'b1;
                    wc_d  = wc_q + 1'b1;
                    if (wc_q == LAST_WC) begin
                        state_d = READY;
                        fr_d    = 1'b1;
                        wc_d    = FULL_WC;
                    end
                end
            end
            READY: begin
                if (arm) begin
                    state_d = CAPTURE;
                    fr_d    = 1'b0;
                    wc_d    = '0;
                    dc_d    = '0;
                end else if (data_in_valid && (dc_q != 16'hFFFF)) begin
                    dc_d = dc_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wc_d    = '0;
                fr_d    = 1'b0;
            end
        endcase
    end

    // Buffer write port.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Reads return real data only while a frame is held and not being re-armed.
    assign rd_ok = (state_q == READY) && !arm;

    // Registered read port with one cycle of latency. rd_valid pulses once per rd_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_ok ? mem[rd_addr] : '0;
        end
    end

    assign frame_ready = fr_q;
    assign capturing   = (state_q == CAPTURE);
    assign word_count  = wc_q;
    assign drop_count  = dc_q;

endmodule
